// File: rtl/alu_pkg.sv
// Shared definitions for the registered ALU/accumulator: operation codes
// and flag index constants used by alu_nucleo and alu_acumulador.
package alu_pkg;

   // Operation select carried on the 2-bit oper input.
   typedef enum logic [1:0] {
      SUM = 2'b00,   // a + b
      RES = 2'b01,   // a - b
      NO  = 2'b10,   // pass b
      ACC = 2'b11    // acc + b, accumulator updated
   } oper_e;

   // Bit positions when the status flags are grouped into a vector.
   localparam int FLAG_CARRY    = 0;
   localparam int FLAG_OVERFLOW = 1;
   localparam int FLAG_ZERO     = 2;
   localparam int FLAG_COUNT    = 3;

endpackage

// File: rtl/alu_nucleo.sv
// Combinational arithmetic core: computes result, carry/borrow and signed
// overflow for SUM/RES/NO/ACC at WIDTH+1 bits.
// Optional feature macro: ALU_SATURATE_EN (clamp signed overflow to the
// most positive / most negative WIDTH-bit value).
module alu_nucleo
   import alu_pkg::*;
#(
   parameter int WIDTH = 14
) (
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   input  logic [WIDTH-1:0] acc_i,
   input  oper_e            oper_i,
   output logic [WIDTH-1:0] result_o,
   output logic             carry_o,
   output logic             overflow_o
);

   localparam int MSB = WIDTH - 1;

   logic [WIDTH-1:0] lhs;
   logic [WIDTH:0]   wide;
   logic [WIDTH-1:0] raw;

   // Wide add/subtract with carry-out and two's-complement overflow detection.
   always_comb begin
      // NOTE: every signal written here gets a default first so no path can infer a latch.
      lhs        = (oper_i == ACC) ? acc_i : a_i;
      wide       = '0;
      carry_o    = 1'b0;
      overflow_o = 1'b0;
      case (oper_i)
         SUM, ACC: begin
            wide       = {1'b0, lhs} + {1'b0, b_i};
            carry_o    = wide[WIDTH];
            overflow_o = (lhs[MSB] == b_i[MSB]) && (wide[MSB] != b_i[MSB]);
         end
         RES: begin
            // Borrow out of the wide subtract is 1 exactly when a < b unsigned.
            wide       = {1'b0, a_i} - {1'b0, b_i};
            carry_o    = wide[WIDTH];
            overflow_o = (a_i[MSB] != b_i[MSB]) && (wide[MSB] != a_i[MSB]);
         end
         NO: begin
            wide = {1'b0, b_i};
         end
         default: ;
      endcase
      raw = wide[MSB:0];
   end

`ifdef ALU_SATURATE_EN
   // On overflow the wrapped sign is the opposite of the true sign, so a
   // negative-looking wrap means the true result overflowed positive.
   always_comb begin
      result_o = raw;
      if (overflow_o) begin
         result_o = raw[MSB] ? {1'b0, {(WIDTH-1){1'b1}}} : {1'b1, {(WIDTH-1){1'b0}}};
      end
   end
`else
   assign result_o = raw;
`endif

endmodule

// File: rtl/alu_acumulador.sv
// Registered ALU with valid/ready handshake on both sides, status flags and
// an internal accumulator. Single output register (no skid): a new operation
// is taken whenever the output is empty or being consumed this cycle.
// Optional feature macro: ALU_SATURATE_EN (saturating SUM/RES/ACC results).
module alu_acumulador
   import alu_pkg::*;
#(
   parameter int               WIDTH    = 14,
   parameter logic [WIDTH-1:0] ACC_INIT = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [1:0]       oper,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             clear_acc,
   output logic [WIDTH-1:0] c,
   output logic             carry,
   output logic             overflow,
   output logic             zero,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] acc
);

   logic [WIDTH-1:0] c_q;
   logic             carry_q;
   logic             overflow_q;
   logic             zero_q;
   logic             out_valid_q;
   logic [WIDTH-1:0] acc_q;
   logic [WIDTH-1:0] acc_d;

   logic             accept;
   logic [WIDTH-1:0] acc_eff;
   logic [WIDTH-1:0] result;
   logic             res_carry;
   logic             res_overflow;

   assign in_ready = !out_valid_q || out_ready;
   assign accept   = in_valid && in_ready;

   // A clear in the same cycle as an ACC takes effect before the add.
   assign acc_eff = clear_acc ? ACC_INIT : acc_q;

   alu_nucleo #(
      .WIDTH (WIDTH)
   ) u_nucleo (
      .a_i        (a),
      .b_i        (b),
      .acc_i      (acc_eff),
      .oper_i     (oper_e'(oper)),
      .result_o   (result),
      .carry_o    (res_carry),
      .overflow_o (res_overflow)
   );

   // Accumulator next state: accepted ACC wins, then clear, else hold.
   always_comb begin
      acc_d = acc_q;
      if (accept && (oper_e'(oper) == ACC)) begin
         acc_d = result;
      end else if (clear_acc) begin
         acc_d = ACC_INIT;
      end
   end

   // Output register and accumulator; reset drops any pending result at once.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         c_q         <= '0;
         carry_q     <= 1'b0;
         overflow_q  <= 1'b0;
         zero_q      <= 1'b0;
         out_valid_q <= 1'b0;
         acc_q       <= ACC_INIT;
      end else begin
         // NOTE: non-blocking assignments so every register samples pre-edge values.
         if (accept) begin
            c_q         <= result;
            carry_q     <= res_carry;
            overflow_q  <= res_overflow;
            zero_q      <= (result == '0);
            out_valid_q <= 1'b1;
         end else if (out_ready) begin
            out_valid_q <= 1'b0;
         end
         acc_q <= acc_d;
      end
   end

   assign c         = c_q;
   assign carry     = carry_q;
   assign overflow  = overflow_q;
   assign zero      = zero_q;
   assign out_valid = out_valid_q;
   assign acc       = acc_q;

endmodule

// File: tb/tb_alu_acumulador.sv
// Directed self-checking bench for alu_acumulador (WIDTH=14, ACC_INIT=0).
// Expected values are hand-computed; saturating expectations apply when
// ALU_SATURATE_EN is defined.
module tb_alu_acumulador;

   localparam int W = 14;

   logic         clk = 1'b0;
   logic         rst;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic [1:0]   oper;
   logic         in_valid;
   logic         in_ready;
   logic         clear_acc;
   logic [W-1:0] c;
   logic         carry;
   logic         overflow;
   logic         zero;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] acc;

   int n_tests = 0;
   int n_fail  = 0;

   alu_acumulador #(
      .WIDTH    (W),
      .ACC_INIT ('0)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .a         (a),
      .b         (b),
      .oper      (oper),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .clear_acc (clear_acc),
      .c         (c),
      .carry     (carry),
      .overflow  (overflow),
      .zero      (zero),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .acc       (acc)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic v, input logic [1:0] op, input logic [W-1:0] aa,
                        input logic [W-1:0] bb, input logic clr, input logic ordy);
      in_valid  = v;
      oper      = op;
      a         = aa;
      b         = bb;
      clear_acc = clr;
      out_ready = ordy;
   endtask

   // Advance past the next rising edge and settle before sampling.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1;
      drive(1'b0, 2'b00, '0, '0, 1'b0, 1'b1);
      #12;
      check("rst_c",        c,         0);
      check("rst_out_valid", out_valid, 0);
      check("rst_acc",      acc,       0);
      check("rst_zero",     zero,      0);
      check("rst_carry",    carry,     0);
      check("rst_in_ready", in_ready,  1);
      tick();
      rst = 1'b0;

      // SUM 16383 + 1 wraps to zero with carry.
      drive(1'b1, 2'b00, 14'd16383, 14'd1, 1'b0, 1'b1);
      tick();
      check("sum_wrap_c",     c,         0);
      check("sum_wrap_carry", carry,     1);
      check("sum_wrap_zero",  zero,      1);
      check("sum_wrap_ovf",   overflow,  0);
      check("sum_wrap_valid", out_valid, 1);

      // SUM 8191 + 1 overflows signed.
      drive(1'b1, 2'b00, 14'd8191, 14'd1, 1'b0, 1'b1);
      tick();
`ifdef ALU_SATURATE_EN
      check("sum_ovf_c", c, 8191);
`else
      check("sum_ovf_c", c, 8192);
`endif
      check("sum_ovf_ovf",   overflow, 1);
      check("sum_ovf_carry", carry,    0);
      check("sum_ovf_zero",  zero,     0);

      // RES 5 - 7 borrows.
      drive(1'b1, 2'b01, 14'd5, 14'd7, 1'b0, 1'b1);
      tick();
      check("res_c",     c,        16382);
      check("res_carry", carry,    1);
      check("res_ovf",   overflow, 0);

      // RES 8192 - 1: negative minus positive overflows.
      drive(1'b1, 2'b01, 14'd8192, 14'd1, 1'b0, 1'b1);
      tick();
`ifdef ALU_SATURATE_EN
      check("res_ovf_c", c, 8192);
`else
      check("res_ovf_c", c, 8191);
`endif
      check("res_ovf_ovf",   overflow, 1);
      check("res_ovf_carry", carry,    0);

      // NO passes b.
      drive(1'b1, 2'b10, 14'd3, 14'd42, 1'b0, 1'b1);
      tick();
      check("no_c",     c,        42);
      check("no_carry", carry,    0);
      check("no_ovf",   overflow, 0);

      // ACC 10, 20, 30 back-to-back.
      drive(1'b1, 2'b11, 14'd999, 14'd10, 1'b0, 1'b1);
      tick();
      check("acc1_c",   c,   10);
      check("acc1_acc", acc, 10);
      drive(1'b1, 2'b11, 14'd999, 14'd20, 1'b0, 1'b1);
      tick();
      check("acc2_c", c, 30);
      drive(1'b1, 2'b11, 14'd999, 14'd30, 1'b0, 1'b1);
      tick();
      check("acc3_c",   c,   60);
      check("acc3_acc", acc, 60);

      // Clear and ACC in the same cycle: clear first, then add.
      drive(1'b1, 2'b11, 14'd0, 14'd4, 1'b1, 1'b1);
      tick();
      check("clr_acc_c",   c,   4);
      check("clr_acc_acc", acc, 4);

      // Drain: no new op, result consumed.
      drive(1'b0, 2'b00, 14'd0, 14'd0, 1'b0, 1'b1);
      tick();
      check("drain_valid", out_valid, 0);
      check("drain_c",     c,         4);
      check("drain_acc",   acc,       4);

      // Clear alone.
      drive(1'b0, 2'b00, 14'd0, 14'd0, 1'b1, 1'b1);
      tick();
      check("clear_acc",   acc,       0);
      check("clear_valid", out_valid, 0);
      check("clear_c",     c,         4);

      // Backpressure: first op enters the empty register.
      drive(1'b1, 2'b00, 14'd100, 14'd1, 1'b0, 1'b0);
      tick();
      check("bp_first_c",     c,         101);
      check("bp_first_valid", out_valid, 1);
      check("bp_in_ready",    in_ready,  0);
      // ACC b=5 held while the consumer stalls.
      drive(1'b1, 2'b11, 14'd0, 14'd5, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         tick();
         check("bp_hold_c",     c,         101);
         check("bp_hold_ready", in_ready,  0);
         check("bp_hold_acc",   acc,       0);
         check("bp_hold_valid", out_valid, 1);
      end
      out_ready = 1'b1;
      #1;
      check("bp_release_ready", in_ready, 1);
      tick();
      check("bp_acc5_c",   c,   5);
      check("bp_acc5_acc", acc, 5);
      drive(1'b1, 2'b11, 14'd0, 14'd7, 1'b0, 1'b1);
      tick();
      check("bp_acc7_c",   c,   12);
      check("bp_acc7_acc", acc, 12);
      drive(1'b0, 2'b11, 14'd0, 14'd7, 1'b0, 1'b1);
      tick();
      check("bp_end_valid", out_valid, 0);
      check("bp_end_acc",   acc,       12);

      // Reset while a result is pending.
      drive(1'b1, 2'b00, 14'd1, 14'd1, 1'b0, 1'b0);
      tick();
      check("pre_rst_c",     c,         2);
      check("pre_rst_valid", out_valid, 1);
      rst = 1'b1;
      #1;
      check("mid_rst_valid", out_valid, 0);
      check("mid_rst_c",     c,         0);
      check("mid_rst_acc",   acc,       0);
      tick();
      rst = 1'b0;
      drive(1'b0, 2'b00, 14'd0, 14'd0, 1'b0, 1'b0);
      #1;
      check("post_rst_ready", in_ready, 1);

      // Normal operation resumes after reset.
      drive(1'b1, 2'b00, 14'd2, 14'd3, 1'b0, 1'b1);
      tick();
      check("post_rst_sum", c, 5);
      check("post_rst_acc", acc, 0);
      drive(1'b0, 2'b00, 14'd0, 14'd0, 1'b0, 1'b1);
      tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
